// File: rtl/allophone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : allophone_sequencer
// Description : Phrase sequencer that reads {last, code} words from an
//               external synchronous ROM and hands allophone codes to the
//               speech core over the ldq / data_stb handshake. It supports a
//               selectable start address, loop mode, abort and an
//               acknowledge timeout.
//               Optional build macro SEQ_LOOP_PAUSE_EN: when looping, one
//               PAUSE_CODE allophone is issued before the phrase restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module allophone_sequencer #(
  parameter int                DATA_W      = 6,
  parameter int                ADDR_W      = 6,
  parameter int                ACK_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] PAUSE_CODE  = 6'h03
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              loop_en,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W:0]   rom_data,
  input  logic              ldq,
  output logic [DATA_W-1:0] data_out,
  output logic              data_stb,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [7:0]        count
);

  // The timer counts WAITACK cycles that have already elapsed, so it only
  // has to reach ACK_TIMEOUT-1.
  localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAITRDY = 3'd2,
    STROBE  = 3'd3,
    WAITACK = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   phrase_base;
  logic                last_flag;
  // FETCH spends its first cycle waiting for the ROM to register the address.
  logic                fetch_wait;
  logic [TIMER_W-1:0]  ack_timer;

`ifdef SEQ_LOOP_PAUSE_EN
  // Set while the inter-loop pause allophone is in flight.
  logic                pausing;
`else
  logic                unused_pause_code;
  assign unused_pause_code = ^PAUSE_CODE;
`endif

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state       <= IDLE;
      rom_addr    <= '0;
      phrase_base <= '0;
      data_out    <= '0;
      data_stb    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      count       <= 8'd0;
      last_flag   <= 1'b0;
      fetch_wait  <= 1'b0;
      ack_timer   <= '0;
`ifdef SEQ_LOOP_PAUSE_EN
      pausing     <= 1'b0;
`endif
    end else begin
      data_stb <= 1'b0;
      done     <= 1'b0;
      if (state != IDLE && abort) begin
        // Abort: drop to IDLE silently; count and data_out are kept.
        state      <= IDLE;
        busy       <= 1'b0;
        fetch_wait <= 1'b0;
`ifdef SEQ_LOOP_PAUSE_EN
        pausing    <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              rom_addr    <= start_addr;
              phrase_base <= start_addr;
              count       <= 8'd0;
              timeout_err <= 1'b0;
              fetch_wait  <= 1'b1;
              busy        <= 1'b1;
              state       <= FETCH;
            end
          end
          FETCH: begin
            if (fetch_wait) begin
              fetch_wait <= 1'b0;
            end else begin
              data_out  <= rom_data[DATA_W-1:0];
              last_flag <= rom_data[DATA_W];
              state     <= WAITRDY;
            end
          end
          WAITRDY: begin
            if (ldq) begin
              data_stb <= 1'b1;
              if (count != 8'hFF) count <= count + 8'd1;
              state    <= STROBE;
            end
          end
          STROBE: begin
            ack_timer <= '0;
            state     <= WAITACK;
          end
          WAITACK: begin
            if (!ldq) begin
`ifdef SEQ_LOOP_PAUSE_EN
              if (pausing) begin
                // rom_addr already points at the phrase base.
                pausing    <= 1'b0;
                fetch_wait <= 1'b1;
                state      <= FETCH;
              end else
`endif
              if (!last_flag) begin
                rom_addr   <= rom_addr + ADDR_W'(1);
                fetch_wait <= 1'b1;
                state      <= FETCH;
              end else if (loop_en) begin
                rom_addr <= phrase_base;
`ifdef SEQ_LOOP_PAUSE_EN
                data_out <= PAUSE_CODE;
                pausing  <= 1'b1;
                state    <= WAITRDY;
`else
                fetch_wait <= 1'b1;
                state      <= FETCH;
`endif
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else if (ack_timer == TIMER_LAST) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
`ifdef SEQ_LOOP_PAUSE_EN
              pausing     <= 1'b0;
`endif
            end else begin
              ack_timer <= ack_timer + TIMER_W'(1);
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
